// File: rtl/spi_adc_emu_pkg.sv
// Shared encodings for the SPI ADC emulator: control-word bit positions,
// channel-mode and frame-FSM state encodings.
package spi_adc_emu_pkg;

  // Control bit positions, counted down from the frame MSB.
  localparam int WRITE_BIT = 0;
  localparam int SEQ_BIT   = 1;
  localparam int ADD_MSB   = 2;

  typedef enum logic {
    MODE_MANUAL   = 1'b0,
    MODE_SEQUENCE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_adc_emulator_if.sv
// SPI pin bundle between the main controller (master) and the ADC emulator (slave).
interface spi_adc_emulator_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi,
                  input  spi_miso, input  spi_miso_oe);
  modport slave  (input  spi_sclk, input  spi_cs_n, input  spi_mosi,
                  output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_sub_frame.sv
// SPI sub-side framing: pin synchronisers, edge detect, shift registers,
// bit counter and end-of-frame valid/error strobes.
module spi_sub_frame
  import spi_adc_emu_pkg::*;
#(
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  spi_adc_emulator_if.slave  spi,
  input  logic [FRAME_W-1:0] tx_word_i,
  output logic [FRAME_W-1:0] rx_word_o,
  output logic               frame_valid_o,
  output logic               frame_err_o
);
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               miso_q, miso_d, oe_q, oe_d;
  logic               valid_q, valid_d, err_q, err_d;

  // cs sync resets low so a frame already in progress at reset release
  // produces no falling edge and is ignored until cs_n cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '1;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.spi_sclk};
      cs_q   <= {cs_q[1:0], spi.spi_cs_n};
      mosi_q <= {mosi_q[0], spi.spi_mosi};
    end
  end

  assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
  assign cs_rise   =  cs_q[1]   & ~cs_q[2];
  assign cs_fall   = ~cs_q[1]   &  cs_q[2];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
          tx_d    = tx_word_i;
          miso_d  = tx_word_i[FRAME_W-1];
          oe_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_ACTIVE: begin
        // cs_n edge takes priority over a coincident sclk edge
        if (cs_rise) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          if (cnt_q == CNT_FULL) valid_d = 1'b1;
          else                   err_d   = 1'b1;
        end else if (sclk_rise) begin
          rx_d = {rx_q[FRAME_W-2:0], mosi_q[1]};
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (sclk_fall) begin
          tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
          miso_d = tx_q[FRAME_W-2];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign rx_word_o       = rx_q;
  assign frame_valid_o   = valid_q;
  assign frame_err_o     = err_q;

endmodule

// File: rtl/spi_adc_emulator.sv
// AD7490-style multi-channel SPI ADC emulator: decodes control words and
// returns per-channel ramp data as {channel, data} frames.
module spi_adc_emulator
  import spi_adc_emu_pkg::*;
#(
  parameter int                 NUM_CH       = 16,
  parameter int                 ADDR_W       = 4,
  parameter int                 DATA_W       = 12,
  parameter int                 FRAME_W      = 16,
  parameter logic [DATA_W-1:0]  STEP         = 12'h111,
  parameter logic [DATA_W-1:0]  SEED_STEP    = 12'h100,
  parameter logic [FRAME_W-1:0] POWERUP_WORD = 16'hABCD
) (
  input  logic               clk,
  input  logic               reset,
  spi_adc_emulator_if.slave  spi,
  output logic               frame_done,
  output logic               frame_err,
  output logic [ADDR_W-1:0]  cur_ch
);
  localparam int PAD = FRAME_W - ADDR_W - DATA_W;

  logic [FRAME_W-1:0] tx_word, rx_word;
  logic               frame_valid, frame_bad;
  logic               wr, seq;
  logic [ADDR_W-1:0]  add_raw, add;
  logic               unused_rx;

  logic               conf_q, conf_d;
  mode_e              mode_q, mode_d;
  logic [ADDR_W-1:0]  last_q, last_d, cur_q, cur_d;
  logic [DATA_W-1:0]  data_q [NUM_CH];
  logic [DATA_W-1:0]  data_d [NUM_CH];

  spi_sub_frame #(.FRAME_W(FRAME_W)) u_frame (
    .clk           (clk),
    .reset         (reset),
    .spi           (spi),
    .tx_word_i     (tx_word),
    .rx_word_o     (rx_word),
    .frame_valid_o (frame_valid),
    .frame_err_o   (frame_bad)
  );

  assign tx_word = conf_q ? (FRAME_W'({cur_q, data_q[cur_q]}) << PAD) : POWERUP_WORD;

  assign wr        = rx_word[FRAME_W-1-WRITE_BIT];
  assign seq       = rx_word[FRAME_W-1-SEQ_BIT];
  assign add_raw   = rx_word[FRAME_W-1-ADD_MSB -: ADDR_W];
  assign add       = (int'(add_raw) >= NUM_CH) ? ADDR_W'(NUM_CH - 1) : add_raw;
  assign unused_rx = ^rx_word;

  always_comb begin
    conf_d = conf_q;
    mode_d = mode_q;
    last_d = last_q;
    cur_d  = cur_q;
    data_d = data_q;
    if (frame_valid) begin
      if (conf_q) data_d[cur_q] = data_q[cur_q] + STEP;
      if (wr) begin
        conf_d = 1'b1;
        if (seq) begin
          mode_d = MODE_SEQUENCE;
          last_d = add;
          cur_d  = '0;
        end else begin
          mode_d = MODE_MANUAL;
          cur_d  = add;
        end
      end else if (mode_q == MODE_SEQUENCE) begin
        cur_d = (cur_q == last_q) ? '0 : cur_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conf_q <= 1'b0;
      mode_q <= MODE_MANUAL;
      last_q <= '0;
      cur_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) data_q[c] <= DATA_W'(c) * SEED_STEP;
    end else begin
      conf_q <= conf_d;
      mode_q <= mode_d;
      last_q <= last_d;
      cur_q  <= cur_d;
      data_q <= data_d;
    end
  end

  assign frame_done = frame_valid;
  assign frame_err  = frame_bad;
  assign cur_ch     = cur_q;

endmodule

// File: tb/tb_spi_adc_emulator.sv
// Bench for spi_adc_emulator: directed frames from the bring-up plan plus
// random frames, checked against a channel-level model of the ADC.
module tb_spi_adc_emulator;
  localparam int NCH  = 12;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_done, frame_err;
  logic [3:0] cur_ch;

  spi_adc_emulator_if spi ();

  spi_adc_emulator #(.NUM_CH(NCH)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi        (spi),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .cur_ch     (cur_ch)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  bit stable = 1'b0, exp_oe = 1'b0;

  // Channel-level model
  int m_data [16];
  bit m_conf, m_seq;
  int m_last, m_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_conf = 0; m_seq = 0; m_last = 0; m_cur = 0;
    for (int c = 0; c < 16; c++) m_data[c] = (c * 'h100) % 4096;
  endfunction

  function automatic logic [15:0] model_word();
    if (!m_conf) return 16'hABCD;
    return 16'((m_cur << 12) | m_data[m_cur]);
  endfunction

  function automatic void model_frame(input logic [15:0] w);
    int a;
    if (m_conf) m_data[m_cur] = (m_data[m_cur] + 'h111) % 4096;
    a = int'(w[13:10]);
    if (a >= NCH) a = NCH - 1;
    if (w[15]) begin
      m_conf = 1;
      if (w[14]) begin m_seq = 1; m_last = a; m_cur = 0; end
      else       begin m_seq = 0; m_cur = a; end
    end else if (m_seq) begin
      m_cur = (m_cur == m_last) ? 0 : m_cur + 1;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model while the bus is settled
  always @(negedge clk) begin
    done_cnt += int'(frame_done);
    err_cnt  += int'(frame_err);
    if (stable && !reset) begin
      chk("miso_oe", spi.spi_miso_oe, exp_oe);
      chk("cur_ch", cur_ch, m_cur);
      chk("strobe_quiet", {frame_done, frame_err}, 0);
    end
  end

  // One SPI frame of nbits sclk cycles; miso sampled just before each fall.
  task automatic do_frame(input int nbits, input logic [15:0] w, output logic [15:0] got);
    logic [15:0] exp_w;
    int dn0, er0;
    exp_w = model_word();
    dn0 = done_cnt; er0 = err_cnt;
    got = '0;
    stable = 0; spi.spi_cs_n = 0; exp_oe = 1;
    tick(6);
    stable = 1;
    for (int b = 0; b < nbits; b++) begin
      if (b < 16) got = {got[14:0], spi.spi_miso};
      else        chk("miso_after_last", spi.spi_miso, 0);
      spi.spi_sclk = 0;
      spi.spi_mosi = (b < 16) ? w[15-b] : 1'b0;
      tick(HALF);
      spi.spi_sclk = 1;
      tick(HALF);
    end
    stable = 0; spi.spi_cs_n = 1; exp_oe = 0;
    tick(6);
    if (nbits >= 16) chk("frame_word", got, exp_w);
    else             chk("abort_prefix", got, exp_w >> (16 - nbits));
    chk("frame_done", done_cnt - dn0, (nbits == 16) ? 1 : 0);
    chk("frame_err", err_cnt - er0, (nbits == 16) ? 0 : 1);
    if (nbits == 16) model_frame(w);
    stable = 1;
    tick(2);
  endtask

  initial begin
    logic [15:0] got, w;
    int dn0, er0, r, n;
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] got, w;
    int dn0, er0, r, n;
    spi.spi_sclk = 1; spi.spi_cs_n = 1; spi.spi_mosi = 0;
    model_reset();
    tick(4);
    reset = 0;
    tick(4);
    chk("rst_miso", spi.spi_miso, 0);
    chk("rst_oe", spi.spi_miso_oe, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cur_ch", cur_ch, 0);
    stable = 1;

    do_frame(16, 16'h0000, got); chk("powerup", got, 16'hABCD);
    do_frame(16, 16'h8C00, got);
    do_frame(16, 16'h0000, got); chk("manual_rd0", got, 16'h3300);
    do_frame(16, 16'h0000, got); chk("manual_rd1", got, 16'h3411);
    do_frame(16, 16'h0000, got); chk("manual_rd2", got, 16'h3522);

    do_frame(16, 16'hC800, got);
    do_frame(16, 16'h0000, got); chk("seq_rd0", got, 16'h0000);
    do_frame(16, 16'h0000, got); chk("seq_rd1", got, 16'h1100);
    do_frame(16, 16'h0000, got); chk("seq_rd2", got, 16'h2200);
    do_frame(16, 16'h0000, got); chk("seq_rd3", got, 16'h0111);

    do_frame(9, 16'h0000, got);  chk("abort_bits", got, 16'h1211 >> 7);
    do_frame(16, 16'h0000, got); chk("after_abort", got, 16'h1211);
    do_frame(17, 16'h0000, got); chk("overclk_word", got, 16'h2311);
    do_frame(16, 16'h0000, got); chk("after_overclk", got, 16'h2311);

    // Reset in the middle of a SEQUENCE-mode read
    dn0 = done_cnt; er0 = err_cnt;
    stable = 0; spi.spi_cs_n = 0; exp_oe = 1;
    tick(6);
    for (int b = 0; b < 8; b++) begin
      spi.spi_sclk = 0; tick(HALF); spi.spi_sclk = 1; tick(HALF);
    end
    reset = 1;
    tick(3);
    chk("midrst_miso", spi.spi_miso, 0);
    chk("midrst_oe", spi.spi_miso_oe, 0);
    chk("midrst_cur_ch", cur_ch, 0);
    reset = 0;
    model_reset(); exp_oe = 0; stable = 1;
    for (int b = 0; b < 8; b++) begin
      spi.spi_sclk = 0; tick(HALF); spi.spi_sclk = 1; tick(HALF);
    end
    spi.spi_cs_n = 1;
    tick(8);
    chk("midrst_no_done", done_cnt - dn0, 0);
    chk("midrst_no_err", err_cnt - er0, 0);
    do_frame(16, 16'h0000, got); chk("midrst_powerup", got, 16'hABCD);

    // Random mix of writes, reads, aborted and over-clocked frames
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      w = 16'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 2) != 0) w[15] = 1'b0;
      if (r == 0)      n = $urandom_range(1, 15);
      else if (r == 1) n = $urandom_range(17, 18);
      else             n = 16;
      do_frame(n, w, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_adc_emulator.md
Name: spi_adc_emulator

Overview:
- Synthesizable, parametrised emulator of an AD7490-style multi-channel SPI ADC for FPGA/simulation test harnesses.
- Oversamples the SPI pins in the system clock domain and decodes the control word shifted in on MOSI.
- Supports manual and sequence channel modes and returns per-channel deterministic ramp data as {channel, data} frames on MISO.
- Sits on the sub side of the team's SPI main controller in loopback benches.

Parameters:
- NUM_CH, 16, number of emulated channels (2..16).
- ADDR_W, 4, channel address width; must satisfy 2**ADDR_W >= NUM_CH.
- DATA_W, 12, conversion result width; FRAME_W must be >= ADDR_W+DATA_W.
- FRAME_W, 16, SPI bits per frame.
- STEP, 12'h111, per-conversion increment of a channel's result, modulo 2**DATA_W.
- SEED_STEP, 12'h100, reset value of channel ch = ch*SEED_STEP mod 2**DATA_W.
- POWERUP_WORD, 16'hABCD, frame returned until the first valid write frame.

Ports:
- clk  in  1  system clock; must be >= 6x spi_sclk frequency.
- reset  in  1  synchronous, active-high.
- spi_sclk  in  1  SPI clock, idle high (mode 2/3 style, like AD7490).
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  main-to-sub data, MSB first.
- spi_miso  out  1  sub-to-main data, MSB first.
- spi_miso_oe  out  1  MISO drive enable; high only while a frame is active.
- frame_done  out  1  one-clk pulse at the end of a valid frame.
- frame_err  out  1  one-clk pulse at the end of a frame with the wrong bit count.
- cur_ch  out  ADDR_W  channel whose result the next frame will return.

Behaviour:
- Input sync and edge detect:
  - sclk, cs_n and mosi each pass through 2 flops, plus a 3rd flop for edge detection.
  - Pin-to-action latency is 3 clk cycles.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, frame_done=0, frame_err=0, cur_ch=0.
  - mode=MANUAL, configured=0, seq_last=0, data[ch]=ch*SEED_STEP, FSM=IDLE.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on a cs_n falling edge:
    - load tx_sr with POWERUP_WORD if configured=0, else {cur_ch, data[cur_ch]} left-justified and zero-padded to FRAME_W;
    - spi_miso=tx_sr MSB, spi_miso_oe=1, bit_cnt=0.
  - In ACTIVE, on an sclk rising edge:
    - shift mosi into rx_sr;
    - bit_cnt increments, saturating at FRAME_W+1.
  - In ACTIVE, on an sclk falling edge: shift tx_sr left by 1 with 0 fill; spi_miso=new MSB.
  - ACTIVE -> IDLE on a cs_n rising edge; spi_miso_oe=0 on the same cycle.
- Frame valid iff bit_cnt==FRAME_W. On a valid frame end, in one cycle:
  - Result update: if configured=1, data[cur_ch] += STEP (wrap).
  - Control decode: rx_sr[FRAME_W-1]=WRITE, [FRAME_W-2]=SEQ, [FRAME_W-3 -: ADDR_W]=ADD.
  - WRITE=1:
    - configured=1, mode=SEQ?SEQUENCE:MANUAL;
    - MANUAL: cur_ch=ADD;
    - SEQUENCE: seq_last=ADD, cur_ch=0.
    - An ADD >= NUM_CH is clamped to NUM_CH-1.
  - WRITE=0: MANUAL leaves cur_ch unchanged; SEQUENCE sets cur_ch = (cur_ch==seq_last) ? 0 : cur_ch+1.
  - frame_done pulses.
- Invalid frame (bit_cnt != FRAME_W, including aborted or over-clocked frames):
  - no state, data or channel change;
  - frame_err pulses.
- Simultaneous cs_n rise and sclk edge in the same clk cycle: the cs_n edge wins and the sclk edge is ignored.
- A cs_n falling edge while ACTIVE cannot occur (cs_n must rise first). Glitches shorter than 2 clk cycles are not guaranteed.
- Reset mid-frame returns all state to reset values immediately; the remaining bits of that frame are ignored until the next cs_n falling edge.
- sclk edges seen while IDLE are ignored.

Decomposition:
- Package spi_adc_emu_pkg holds:
  - control bit position localparams (WRITE_BIT, SEQ_BIT, ADD_MSB);
  - mode encoding (MODE_MANUAL=0, MODE_SEQUENCE=1);
  - FSM state encoding.
- One sub-module, spi_sub_frame: synchronizers, edge detect, shift registers, bit counter and the valid/err strobes, exporting rx_word and a load interface.
- The top level, spi_adc_emulator, owns channel sequencing and the per-channel data array.

Test Plan:
- Power-up read: reset, then one 16-bit frame with MOSI=0 -> MISO returns 16'hABCD, frame_done=1, cur_ch stays 0, configured stays 0.
- Manual mode: write 16'h8C00 (WRITE=1, SEQ=0, ADD=3), then 3 read frames with MOSI=0 -> MISO returns 16'h3300, 16'h3411, 16'h3522.
- Sequence mode: write 16'hC800 (SEQ=1, ADD=2), then 4 reads -> 16'h0000, 16'h1100, 16'h2200, 16'h0111 (channel wraps after seq_last=2).
- Aborted frame: after the sequence setup, cs_n rises after 9 sclk cycles -> frame_err pulse, no frame_done, and the next full frame returns the same word the aborted frame started.
- Over-clocked frame: 17 sclk cycles -> frame_err, no state change, MISO=0 after bit 16, spi_miso_oe=0 after cs_n rises.
- Reset mid-frame: assert reset at bit 8 of a read in SEQUENCE mode -> all outputs return to reset values, and the next frame returns 16'hABCD.
